sr_pulse_driver: RTL and testbench

Drive side of the set/reset latch interface. Accepts desired-level requests over a valid/ready handshake and converts each into a clean, fixed-width set or reset pulse. The pulses are guaranteed mutually exclusive and spaced. Sits between control logic and an `sr_latch`-style storage element, and keeps a shadow copy of the latch state so redundant requests cost no pulse.

---
 rtl/sr_pulse_driver.sv | 110 +++++++++++
 tb/tb_sr_pulse_driver.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_driver.sv
// Set/reset latch drive side: turns level requests into fixed-width,
// mutually exclusive s/r pulses and tracks the latch state in q_model.
`timescale 1ns/1ps
module sr_pulse_driver #(
  parameter int unsigned PULSE_W     = 2,
  parameter int unsigned GAP_W       = 1,
  parameter bit          FORCE_PULSE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  output logic q_model,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_C = 8'(PULSE_W - 1);
  localparam logic [7:0] GAP_C   =
    (GAP_W == 0) ? 8'd0 : 8'(GAP_W - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       s_d, r_d, q_d;
  logic       lvl, lvl_d;
  logic       fire;

  // A matching level is consumed without a pulse unless forced.
  assign fire = req_valid &&
                ((req_level != q_model) || FORCE_PULSE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    s_d     = s;
    r_d     = r;
    q_d     = q_model;
    lvl_d   = lvl;
    unique case (state)
      IDLE: begin
        if (fire) begin
          lvl_d   = req_level;
          cnt_d   = PULSE_C;
          s_d     = req_level;
          r_d     = !req_level;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt != 8'd0) begin
          cnt_d = cnt - 8'd1;
        end else begin
          s_d = 1'b0;
          r_d = 1'b0;
          q_d = lvl;
          if (GAP_W == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = GAP_C;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        s_d = 1'b0;
        r_d = 1'b0;
        if (cnt != 8'd0) begin
          cnt_d = cnt - 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      s       <= 1'b0;
      r       <= 1'b0;
      q_model <= 1'b0;
      lvl     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      s       <= s_d;
      r       <= r_d;
      q_model <= q_d;
      lvl     <= lvl_d;
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver; four instances cover the
// default, forced, shortest and longest parameter settings.
`timescale 1ns/1ps
module tb_sr_pulse_driver;

  logic clk, rst, req_valid, req_level;
  logic rdy0, s0, r0, q0, bsy0;
  logic rdy1, s1, r1, q1, bsy1;
  logic rdy2, s2, r2, q2, bsy2;
  logic rdy3, s3, r3, q3, bsy3;
  logic [4:0] o0, o1, o2, o3;
  int vec, bad;

  // Bundles are {s, r, q_model, busy, req_ready}.
  assign o0 = {s0, r0, q0, bsy0, rdy0};
  assign o1 = {s1, r1, q1, bsy1, rdy1};
  assign o2 = {s2, r2, q2, bsy2, rdy2};
  assign o3 = {s3, r3, q3, bsy3, rdy3};

  sr_pulse_driver #(.PULSE_W(2), .GAP_W(1), .FORCE_PULSE(1'b0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_level(req_level), .req_ready(rdy0), .s(s0), .r(r0),
    .q_model(q0), .busy(bsy0));

  sr_pulse_driver #(.PULSE_W(2), .GAP_W(1), .FORCE_PULSE(1'b1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_level(req_level), .req_ready(rdy1), .s(s1), .r(r1),
    .q_model(q1), .busy(bsy1));

  sr_pulse_driver #(.PULSE_W(1), .GAP_W(0), .FORCE_PULSE(1'b0)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_level(req_level), .req_ready(rdy2), .s(s2), .r(r2),
    .q_model(q2), .busy(bsy2));

  sr_pulse_driver #(.PULSE_W(255), .GAP_W(1), .FORCE_PULSE(1'b0)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_level(req_level), .req_ready(rdy3), .s(s3), .r(r3),
    .q_model(q3), .busy(bsy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(s0 && r0));
    assert (!(s1 && r1));
    assert (!(s2 && r2));
    assert (!(s3 && r3));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    req_valid = 1'b0;
    req_level = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b1;
    req_level = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (o0 !== 5'b00001) begin
        bad++;
        $display("FAIL reset_u0 c%0d: got %b want 00001", i, o0);
      end
      vec++;
      if (o3 !== 5'b00001) begin
        bad++;
        $display("FAIL reset_u3 c%0d: got %b want 00001", i, o3);
      end
    end
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    vec++;
    if (o0 !== 5'b00001) begin
      bad++;
      $display("FAIL reset_release: got %b want 00001", o0);
    end
  endtask

  task automatic test_set_reset();
    logic [4:0] exp_s [4];
    logic [4:0] exp_r [4];
    reset_all();
    exp_s = '{5'b10010, 5'b10010, 5'b00110, 5'b00101};
    exp_r = '{5'b01110, 5'b01110, 5'b00010, 5'b00001};
    req_valid = 1'b1;
    req_level = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid = 1'b0;
      vec++;
      if (o0 !== exp_s[i]) begin
        bad++;
        $display("FAIL set_c%0d: got %b want %b", i, o0, exp_s[i]);
      end
    end
    req_valid = 1'b1;
    req_level = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid = 1'b0;
      vec++;
      if (o0 !== exp_r[i]) begin
        bad++;
        $display("FAIL rst_c%0d: got %b want %b", i, o0, exp_r[i]);
      end
    end
  endtask

  task automatic test_redundant();
    reset_all();
    req_valid = 1'b1;
    req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    vec++;
    if ({o0, o1} !== {5'b00101, 5'b00101}) begin
      bad++;
      $display("FAIL redund_pre: got %b/%b want 00101/00101", o0, o1);
    end
    req_valid = 1'b1;
    req_level = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec++;
      if (o0 !== 5'b00101) begin
        bad++;
        $display("FAIL redund_c%0d: got %b want 00101", i, o0);
      end
      vec++;
      if (o1 !== 5'b10110) begin
        bad++;
        $display("FAIL force_c%0d: got %b want 10110", i, o1);
      end
    end
    req_valid = 1'b0;
    tick();
    vec++;
    if (o1 !== 5'b00110) begin
      bad++;
      $display("FAIL force_fall: got %b want 00110", o1);
    end
    tick();
    vec++;
    if (o1 !== 5'b00101) begin
      bad++;
      $display("FAIL force_idle: got %b want 00101", o1);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp2;
    reset_all();
    req_valid = 1'b1;
    req_level = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp2 = {(i % 8) < 2, ((i % 8) >= 4) && ((i % 8) < 6)};
      vec++;
      if ({s0, r0} !== exp2) begin
        bad++;
        $display("FAIL held_c%0d: got sr=%b want %b", i, {s0, r0}, exp2);
      end
      if (i % 4 == 0) req_level = ~req_level;
    end
    req_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_mid_reset();
    reset_all();
    req_valid = 1'b1;
    req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    vec++;
    if (o0 !== 5'b10010) begin
      bad++;
      $display("FAIL mid_pre: got %b want 10010", o0);
    end
    #2;
    rst = 1'b0;
    #1;
    vec++;
    if (o0 !== 5'b00001) begin
      bad++;
      $display("FAIL mid_async: got %b want 00001", o0);
    end
    tick();
    rst = 1'b1;
    req_valid = 1'b1;
    req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    vec++;
    if (o0 !== 5'b10010) begin
      bad++;
      $display("FAIL mid_re_c0: got %b want 10010", o0);
    end
    tick();
    vec++;
    if (o0 !== 5'b10010) begin
      bad++;
      $display("FAIL mid_re_c1: got %b want 10010", o0);
    end
    tick();
    vec++;
    if (o0 !== 5'b00110) begin
      bad++;
      $display("FAIL mid_re_end: got %b want 00110", o0);
    end
  endtask

  task automatic test_corners();
    logic [4:0] exp_c [4];
    int n;
    reset_all();
    exp_c = '{5'b10010, 5'b00101, 5'b01110, 5'b00001};
    req_valid = 1'b1;
    req_level = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid = (i >= 1);
      req_level = 1'b0;
      vec++;
      if (o2 !== exp_c[i]) begin
        bad++;
        $display("FAIL w1g0_c%0d: got %b want %b", i, o2, exp_c[i]);
      end
    end
    reset_all();
    req_valid = 1'b1;
    req_level = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (s3 && n < 300) begin
      n++;
      tick();
    end
    vec++;
    if (n !== 255) begin
      bad++;
      $display("FAIL w255_len: got %0d want 255", n);
    end
    vec++;
    if (o3 !== 5'b00110) begin
      bad++;
      $display("FAIL w255_end: got %b want 00110", o3);
    end
  endtask

  initial begin
    vec = 0;
    bad = 0;
    rst = 1'b0;
    req_valid = 1'b0;
    req_level = 1'b0;
    test_reset();
    test_set_reset();
    test_redundant();
    test_back_to_back();
    test_mid_reset();
    test_corners();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
